// File: rtl/ntt_pointwise_sequencer.sv
// ntt_pointwise_sequencer
//   Sequences one NTT-domain polynomial product through an external combinational
//   base-case multiplier, one coefficient pair per beat. Each accepted pair
//   (a0,a1,b0,b1) is presented to the multiplier together with the per-pair twiddle
//   GAMMA[idx], and the returned (c0,c1) is captured into a single-entry valid/ready
//   output register tagged with the pair index and a last flag.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start                      1-cycle pulse, begins a polynomial (honoured when idle)
//   in_valid/in_ready          input pair handshake
//   in_a0/in_a1/in_b0/in_b1    input coefficients, expected < Q
//   mul_a0..mul_b1             operands to the multiplier (pass-through of in_*)
//   mul_gamma, mul_q           twiddle for the current pair, modulus
//   mul_c0/mul_c1              multiplier results, same cycle
//   out_valid/out_ready        output beat handshake
//   out_c0/out_c1              registered results
//   out_idx, out_last          pair index of the result, high on the final pair
//   busy                       polynomial in progress
//   done                       1-cycle pulse on the handshake of the final result
//   range_err                  sticky: an accepted coefficient was >= Q; cleared by start

module ntt_pointwise_sequencer #(
  parameter int unsigned N_PAIRS = 128,
  parameter int unsigned Q       = 3329,
  parameter int unsigned ZETA    = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_a0,
  input  logic [15:0]                in_a1,
  input  logic [15:0]                in_b0,
  input  logic [15:0]                in_b1,
  output logic [15:0]                mul_a0,
  output logic [15:0]                mul_a1,
  output logic [15:0]                mul_b0,
  output logic [15:0]                mul_b1,
  output logic [15:0]                mul_gamma,
  output logic [15:0]                mul_q,
  input  logic [15:0]                mul_c0,
  input  logic [15:0]                mul_c1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_c0,
  output logic [15:0]                out_c1,
  output logic [$clog2(N_PAIRS)-1:0] out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       range_err
);

  localparam int unsigned IdxW = $clog2(N_PAIRS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_PAIRS - 1);
  localparam logic [15:0] QW = 16'(Q);

  typedef logic [N_PAIRS-1:0][15:0] gamma_tbl_t;

  // GAMMA[i] = ZETA^(2*bitrev(i)+1) mod Q, evaluated at elaboration.
  function automatic gamma_tbl_t build_gamma();
    gamma_tbl_t  tbl;
    int unsigned br;
    int unsigned e;
    int unsigned base;
    int unsigned acc;
    tbl = '0;
    for (int unsigned i = 0; i < N_PAIRS; i++) begin
      br = 0;
      for (int unsigned b = 0; b < IdxW; b++) begin
        if (((i >> b) & 32'd1) != 0) br = br | (32'd1 << (IdxW - 1 - b));
      end
      e    = 2 * br + 1;
      base = ZETA % Q;
      acc  = 1;
      // Square-and-multiply; operands stay below Q so products fit in 32 bits.
      for (int unsigned k = 0; k < 16; k++) begin
        if (((e >> k) & 32'd1) != 0) acc = (acc * base) % Q;
        base = (base * base) % Q;
      end
      tbl[i] = 16'(acc);
    end
    return tbl;
  endfunction

  localparam gamma_tbl_t GammaTbl = build_gamma();

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IdxW-1:0]   r_idx;
  logic              r_out_valid;
  logic [15:0]       r_out_c0;
  logic [15:0]       r_out_c1;
  logic [IdxW-1:0]   r_out_idx;
  logic              r_out_last;
  logic              r_range_err;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_pop;
  logic              w_is_last;
  logic              w_range_bad;
  logic              w_done;

  // Single output register: a new pair may enter only if the slot is empty or
  // is being drained in this same cycle.
  assign w_in_ready  = (r_state == StRun) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_pop       = r_out_valid && out_ready;
  assign w_is_last   = (r_idx == LastIdx);
  assign w_range_bad = (in_a0 >= QW) || (in_a1 >= QW) || (in_b0 >= QW) || (in_b1 >= QW);

  assign mul_a0    = in_a0;
  assign mul_a1    = in_a1;
  assign mul_b0    = in_b0;
  assign mul_b1    = in_b1;
  assign mul_gamma = GammaTbl[r_idx];
  assign mul_q     = QW;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_c0    = r_out_c0;
  assign out_c1    = r_out_c1;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = (r_state != StIdle);
  assign done      = w_done;
  assign range_err = r_range_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) w_state_nxt = StRun;
      end
      StRun: begin
        if (w_accept && w_is_last) w_state_nxt = StDrain;
      end
      StDrain: begin
        // In drain the only occupant of the output slot is the last result.
        if (w_pop) begin
          w_state_nxt = StIdle;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_c0    <= '0;
      r_out_c1    <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      if ((r_state == StIdle) && start) begin
        r_idx       <= '0;
        r_range_err <= 1'b0;
      end
      if (w_accept) begin
        r_out_c0   <= mul_c0;
        r_out_c1   <= mul_c1;
        r_out_idx  <= r_idx;
        r_out_last <= w_is_last;
        r_idx      <= r_idx + IdxW'(1);
        if (w_range_bad) r_range_err <= 1'b1;
      end
      // Simultaneous pop and accept keeps the slot full.
      if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntt_pointwise_sequencer.sv
module tb_ntt_pointwise_sequencer;

  localparam int unsigned QM = 3329;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a0, in_a1, in_b0, in_b1;
  logic [15:0] mul_a0, mul_a1, mul_b0, mul_b1, mul_gamma, mul_q;
  logic [15:0] mul_c0, mul_c1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c0, out_c1;
  logic [6:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        range_err;

  ntt_pointwise_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a0     (in_a0),
    .in_a1     (in_a1),
    .in_b0     (in_b0),
    .in_b1     (in_b1),
    .mul_a0    (mul_a0),
    .mul_a1    (mul_a1),
    .mul_b0    (mul_b0),
    .mul_b1    (mul_b1),
    .mul_gamma (mul_gamma),
    .mul_q     (mul_q),
    .mul_c0    (mul_c0),
    .mul_c1    (mul_c1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c0    (out_c0),
    .out_c1    (out_c1),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .range_err (range_err)
  );

  // Base-case multiply: c0 = a0*b0 + a1*b1*gamma, c1 = a0*b1 + a1*b0 (mod Q).
  function automatic logic [15:0] ref_c0(input logic [15:0] a0, a1, b0, b1, g);
    int unsigned t;
    t = (32'(a1) * 32'(b1)) % QM;
    t = ((32'(a0) * 32'(b0)) % QM + (t * 32'(g)) % QM) % QM;
    return 16'(t);
  endfunction

  function automatic logic [15:0] ref_c1(input logic [15:0] a0, a1, b0, b1);
    int unsigned t;
    t = ((32'(a0) * 32'(b1)) % QM + (32'(a1) * 32'(b0)) % QM) % QM;
    return 16'(t);
  endfunction

  // Multiplier model attached to the mul_* ports.
  assign mul_c0 = ref_c0(mul_a0, mul_a1, mul_b0, mul_b1, mul_gamma);
  assign mul_c1 = ref_c1(mul_a0, mul_a1, mul_b0, mul_b1);

  typedef struct packed {
    logic [15:0] c0;
    logic [15:0] c1;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] tb_gamma[128];
  int          tb_idx;
  int          n_checks;
  int          n_errors;
  int          n_pops;
  int          done_cnt;
  int          cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      tb_idx = 0;
    end else begin
      if (start && !busy) begin
        tb_idx   = 0;
        done_cnt = 0;
      end
      if (done) done_cnt++;
      if (in_valid && in_ready) begin
        e.c0   = ref_c0(in_a0, in_a1, in_b0, in_b1, tb_gamma[tb_idx]);
        e.c1   = ref_c1(in_a0, in_a1, in_b0, in_b1);
        e.idx  = 7'(tb_idx);
        e.last = (tb_idx == 127);
        sb_q.push_back(e);
        tb_idx = (tb_idx + 1) % 128;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          n_pops++;
          check_eq("out_c0", out_c0, e.c0);
          check_eq("out_c1", out_c1, e.c1);
          check_eq("out_idx", out_idx, e.idx);
          check_eq("out_last", out_last, e.last);
          check_eq("done_on_pop", done, e.last);
        end
      end else begin
        check_eq("done_quiet", done, 0);
      end
    end
  end

  task automatic chk_idle_zero();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_c0", out_c0, 0);
    check_eq("rst_out_c1", out_c1, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_range_err", range_err, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    start    = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle_zero();
    sb_q.delete();
    tb_idx = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle_zero();
  endtask

  task automatic pulse_start();
    sync();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_pair(input logic [15:0] a0, a1, b0, b1);
    bit ok;
    in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 0, 1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send_pair(16'($urandom_range(0, QM - 1)), 16'($urandom_range(0, QM - 1)),
              16'($urandom_range(0, QM - 1)), 16'($urandom_range(0, QM - 1)));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          lit[4];
    int          c_start;
    int          pops0;
    int unsigned br;
    int unsigned acc;
    logic [15:0] h0, h1, h2, h3;

    lit = '{17, 3312, 2761, 568};
    for (int i = 0; i < 128; i++) begin
      br = 0;
      for (int b = 0; b < 7; b++) if (((i >> b) & 1) != 0) br = br | (1 << (6 - b));
      acc = 1;
      for (int k = 0; k < int'(2 * br + 1); k++) acc = (acc * 17) % QM;
      tb_gamma[i] = 16'(acc);
    end

    n_checks = 0; n_errors = 0; n_pops = 0; done_cnt = 0; cyc = 0; tb_idx = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0;

    #12 chk_idle_zero();
    check_eq("mul_q", mul_q, QM);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle_zero();

    // Reset in the middle of a polynomial.
    pulse_start();
    for (int k = 0; k < 10; k++) send_rand();
    do_reset();

    // First pair after restart: latency one cycle, index 0.
    pulse_start();
    send_pair(16'd1, 16'd0, 16'd5, 16'd0);
    @(negedge clk);
    check_eq("t2_valid", out_valid, 1);
    check_eq("t2_c0", out_c0, 5);
    check_eq("t2_c1", out_c1, 0);
    check_eq("t2_idx", out_idx, 0);
    sync();
    do_reset();

    // Gamma table leading entries.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      send_pair(16'd0, 16'd1, 16'd0, 16'd1);
      @(negedge clk);
      check_eq("t3_gamma_c0", out_c0, 32'(lit[k]));
      check_eq("t3_c1", out_c1, 0);
      check_eq("t3_idx", out_idx, 32'(k));
      sync();
    end
    do_reset();

    // Full polynomial back-to-back.
    pulse_start();
    c_start = cyc;
    for (int k = 0; k < 128; k++) send_rand();
    check_eq("t4_b2b_cycles", 32'(cyc - c_start), 128);
    @(negedge clk);
    check_eq("t4_done", done, 1);
    check_eq("t4_last", out_last, 1);
    check_eq("t4_busy_drain", busy, 1);
    @(negedge clk);
    check_eq("t4_busy_fall", busy, 0);
    check_eq("t4_done_cnt", 32'(done_cnt), 1);
    check_eq("t4_sb_empty", 32'(sb_q.size()), 0);
    check_eq("t4_range_err", range_err, 0);

    // Output backpressure at beat 3.
    pulse_start();
    pops0 = n_pops;
    for (int k = 0; k < 4; k++) send_rand();
    out_ready = 1'b0;
    h0 = 16'($urandom_range(0, QM - 1)); h1 = 16'($urandom_range(0, QM - 1));
    h2 = 16'($urandom_range(0, QM - 1)); h3 = 16'($urandom_range(0, QM - 1));
    in_a0 = h0; in_a1 = h1; in_b0 = h2; in_b1 = h3;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t5_sb_depth", 32'(sb_q.size()), 1);
      check_eq("t5_in_ready", in_ready, 0);
      check_eq("t5_valid", out_valid, 1);
      check_eq("t5_hold_c0", out_c0, sb_q[0].c0);
      check_eq("t5_hold_c1", out_c1, sb_q[0].c1);
      check_eq("t5_hold_idx", out_idx, 3);
    end
    sync();
    out_ready = 1'b1;
    send_pair(h0, h1, h2, h3);
    for (int k = 5; k < 128; k++) send_rand();
    wait_idle();
    check_eq("t5_pop_count", 32'(n_pops - pops0), 128);
    check_eq("t5_sb_empty", 32'(sb_q.size()), 0);

    // Range error, start while busy.
    pulse_start();
    check_eq("t6_rerr_init", range_err, 0);
    send_pair(16'd3329, 16'd0, 16'd1, 16'd0);
    @(negedge clk);
    check_eq("t6_rerr_set", range_err, 1);
    check_eq("t6_idx0", out_idx, 0);
    pulse_start();
    check_eq("t6_busy_kept", busy, 1);
    check_eq("t6_rerr_kept", range_err, 1);
    send_rand();
    @(negedge clk);
    check_eq("t6_no_restart", out_idx, 1);
    sync();
    for (int k = 2; k < 128; k++) send_rand();
    wait_idle();
    check_eq("t6_rerr_sticky", range_err, 1);
    pulse_start();
    @(negedge clk);
    check_eq("t6_rerr_cleared", range_err, 0);
    check_eq("t6_busy", busy, 1);
    check_eq("t6_sb_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
